counter_modulo4_sequencer: RTL and testbench

Synchronous controller that drives the asynchronous modulo-4 ripple counter through its `clockpulse` / `clear_` pins. On a start command it optionally clears the counter, then issues a programmed number of clean pulses at a fixed rate. It checks the settled counter output after every pulse and reports progress, wrap-arounds and mismatches. It sits between lab stimulus logic (switches/FSM) and the counter, replacing hand-toggled pulse generation.

---
 rtl/counter_modulo4_sequencer.sv | 179 +++++++++++++++++
 tb/tb_counter_modulo4_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_modulo4_sequencer.sv
// Sequencer for an external asynchronous modulo-4 ripple counter: optional clear phase,
// a programmed burst of fixed-rate pulses, and a settled-output check after every pulse.
module counter_modulo4_sequencer #(
    parameter int HALF_PERIOD  = 2,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clockpulse,
    input  logic       clear,
    input  logic       start,
    input  logic       clear_first,
    input  logic [7:0] pulse_count,
    input  logic [1:0] counter_q,
    output logic       cnt_cp,
    output logic       cnt_clr_,
    output logic       busy,
    output logic       done,
    output logic [7:0] pulses_sent,
    output logic [6:0] wrap_count,
    output logic       error
);
    localparam int MAX_LEN = (HALF_PERIOD > CLEAR_CYCLES) ? HALF_PERIOD : CLEAR_CYCLES;
    localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PULSE_HI,
        S_PULSE_LO,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic [7:0]    count_reg;
    logic [1:0]    exp_reg;
    logic          cnt_cp_reg;
    logic          cnt_clr_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [7:0]    pulses_reg;
    logic [6:0]    wrap_reg;
    logic          error_reg;

    // Values taken on entry to PULSE_HI; from IDLE the run starts at the sampled counter value.
    logic [1:0] step_base;
    logic [1:0] exp_step_next;
    logic [6:0] wrap_step_next;
    logic [7:0] pulses_step_next;

    always_comb begin
        step_base        = (state_reg == S_IDLE) ? counter_q : exp_reg;
        exp_step_next    = step_base + 2'd1;
        wrap_step_next   = ((state_reg == S_IDLE) ? 7'd0 : wrap_reg)
                           + {6'd0, (step_base == 2'd3)};
        pulses_step_next = ((state_reg == S_IDLE) ? 8'd0 : pulses_reg) + 8'd1;
    end

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            count_reg   <= '0;
            exp_reg     <= '0;
            cnt_cp_reg  <= 1'b0;
            cnt_clr_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            pulses_reg  <= '0;
            wrap_reg    <= '0;
            error_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    cnt_cp_reg  <= 1'b0;
                    cnt_clr_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    if (start) begin
                        count_reg  <= pulse_count;
                        pulses_reg <= '0;
                        wrap_reg   <= '0;
                        error_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        if (clear_first) begin
                            exp_reg     <= 2'd0;
                            cnt_clr_reg <= 1'b0;
                            timer_reg   <= CLEAR_LOAD;
                            state_reg   <= S_CLEAR;
                        end else if (pulse_count != 8'd0) begin
                            exp_reg    <= exp_step_next;
                            wrap_reg   <= wrap_step_next;
                            pulses_reg <= pulses_step_next;
                            cnt_cp_reg <= 1'b1;
                            timer_reg  <= HALF_LOAD;
                            state_reg  <= S_PULSE_HI;
                        end else begin
                            exp_reg   <= counter_q;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end

                S_CLEAR: begin
                    if (timer_reg == '0) begin
                        cnt_clr_reg <= 1'b1;
                        if (count_reg != 8'd0) begin
                            exp_reg    <= exp_step_next;
                            wrap_reg   <= wrap_step_next;
                            pulses_reg <= pulses_step_next;
                            cnt_cp_reg <= 1'b1;
                            timer_reg  <= HALF_LOAD;
                            state_reg  <= S_PULSE_HI;
                        end else begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                S_PULSE_HI: begin
                    if (timer_reg == '0) begin
                        cnt_cp_reg <= 1'b0;
                        timer_reg  <= HALF_LOAD;
                        state_reg  <= S_PULSE_LO;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                S_PULSE_LO: begin
                    if (timer_reg == '0) begin
                        // The counter has had a full low half-period to settle; a miss is recorded, not fatal.
                        if (counter_q != exp_reg) begin
                            error_reg <= 1'b1;
                        end
                        if (pulses_reg < count_reg) begin
                            exp_reg    <= exp_step_next;
                            wrap_reg   <= wrap_step_next;
                            pulses_reg <= pulses_step_next;
                            cnt_cp_reg <= 1'b1;
                            timer_reg  <= HALF_LOAD;
                            state_reg  <= S_PULSE_HI;
                        end else begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cnt_cp      = cnt_cp_reg;
    assign cnt_clr_    = cnt_clr_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign pulses_sent = pulses_reg;
    assign wrap_count  = wrap_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_counter_modulo4_sequencer.sv
// Bench for counter_modulo4_sequencer: an ideal (or stuck) counter model in the feedback
// loop, and every run checked cycle by cycle against waveforms derived from run parameters.
module tb_counter_modulo4_sequencer;
    localparam int H_T = 2;
    localparam int C_T = 2;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic       clear_first;
    logic [7:0] pulse_count;
    logic [1:0] counter_q;
    logic       cnt_cp;
    logic       cnt_clr_;
    logic       busy;
    logic       done;
    logic [7:0] pulses_sent;
    logic [6:0] wrap_count;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;

    // External counter model, with hooks to preload it or make it ignore pulses.
    logic [1:0] ctr_model   = 2'd0;
    logic       cp_prev     = 1'b0;
    logic       preload_req = 1'b0;
    logic [1:0] preload_val = 2'd0;
    logic       stuck_model = 1'b0;

    counter_modulo4_sequencer #(
        .HALF_PERIOD (H_T),
        .CLEAR_CYCLES(C_T)
    ) dut (
        .clockpulse (clk),
        .clear      (clear),
        .start      (start),
        .clear_first(clear_first),
        .pulse_count(pulse_count),
        .counter_q  (counter_q),
        .cnt_cp     (cnt_cp),
        .cnt_clr_   (cnt_clr_),
        .busy       (busy),
        .done       (done),
        .pulses_sent(pulses_sent),
        .wrap_count (wrap_count),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (cnt_clr_ === 1'b0) ctr_model = 2'd0;
        else if (preload_req) ctr_model = preload_val;
        else if (cnt_cp === 1'b1 && cp_prev == 1'b0 && !stuck_model) ctr_model = ctr_model + 2'd1;
        cp_prev = (cnt_cp === 1'b1);
    end

    assign counter_q = ctr_model;

    function automatic int exp_wraps(input int e0, input int p);
        int w = 0;
        for (int k = 1; k <= p; k++) if (((e0 + k - 1) % 4) == 3) w++;
        return w;
    endfunction

    // One start-to-done run; start is raised in the current cycle (cycle 0).
    task automatic do_run(input bit cf, input int n, input bit use_pre, input int q0_in,
                          input bit stuck, input int glitch_t);
        int base, done_t, e0, sv, bad_k, e_p, e_w, q0, final_q;
        logic e_cp, e_clr, e_busy, e_done, e_err;
        stuck_model = stuck;
        if (use_pre) begin
            preload_val = 2'(q0_in);
            preload_req = 1'b1;
            @(negedge clk);
            preload_req = 1'b0;
        end
        q0     = int'(ctr_model);
        base   = cf ? C_T : 0;
        done_t = 1 + base + 2 * H_T * n;
        e0     = cf ? 0 : q0;
        sv     = e0;
        bad_k  = 0;
        if (stuck) begin
            for (int k = 1; k <= n; k++) begin
                if (bad_k == 0 && ((e0 + k) % 4) != sv) bad_k = k;
            end
        end
        final_q = stuck ? sv : ((e0 + n) % 4);

        start       = 1'b1;
        clear_first = cf;
        pulse_count = 8'(n);
        for (int t = 1; t <= done_t; t++) begin
            @(negedge clk);
            e_cp   = (n > 0) && (t > base) && (t <= base + 2 * H_T * n)
                     && (((t - base - 1) % (2 * H_T)) < H_T);
            e_clr  = !(cf && t <= base);
            e_busy = (t < done_t);
            e_done = (t == done_t);
            if (t <= base) e_p = 0;
            else begin
                e_p = (t - base - 1) / (2 * H_T) + 1;
                if (e_p > n) e_p = n;
            end
            e_w   = exp_wraps(e0, e_p);
            e_err = (bad_k != 0) && (t > base + 2 * H_T * bad_k);

            n_cmp += 7;
            if (cnt_cp !== e_cp) begin
                n_bad++; $display("FAIL cnt_cp t=%0d got=%0b want=%0b", t, cnt_cp, e_cp);
            end
            if (cnt_clr_ !== e_clr) begin
                n_bad++; $display("FAIL cnt_clr_ t=%0d got=%0b want=%0b", t, cnt_clr_, e_clr);
            end
            if (busy !== e_busy) begin
                n_bad++; $display("FAIL busy t=%0d got=%0b want=%0b", t, busy, e_busy);
            end
            if (done !== e_done) begin
                n_bad++; $display("FAIL done t=%0d got=%0b want=%0b", t, done, e_done);
            end
            if (pulses_sent !== 8'(e_p)) begin
                n_bad++; $display("FAIL pulses_sent t=%0d got=%0d want=%0d", t, pulses_sent, e_p);
            end
            if (wrap_count !== 7'(e_w)) begin
                n_bad++; $display("FAIL wrap_count t=%0d got=%0d want=%0d", t, wrap_count, e_w);
            end
            if (error !== e_err) begin
                n_bad++; $display("FAIL error t=%0d got=%0b want=%0b", t, error, e_err);
            end

            start = (t == glitch_t);
            if (start) begin
                pulse_count = 8'($urandom);
                clear_first = 1'($urandom);
            end
        end

        // The cycle after done: back in IDLE, results held, any start seen in DONE ignored.
        @(negedge clk);
        n_cmp += 5;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL post_idle busy=%0b done=%0b want 0/0", busy, done);
        end
        if (pulses_sent !== 8'(n)) begin
            n_bad++; $display("FAIL post_pulses got=%0d want=%0d", pulses_sent, n);
        end
        if (wrap_count !== 7'(exp_wraps(e0, n))) begin
            n_bad++; $display("FAIL post_wraps got=%0d want=%0d", wrap_count, exp_wraps(e0, n));
        end
        if (error !== (bad_k != 0)) begin
            n_bad++; $display("FAIL post_error got=%0b want=%0b", error, (bad_k != 0));
        end
        if (ctr_model !== 2'(final_q)) begin
            n_bad++; $display("FAIL final_counter got=%0d want=%0d", ctr_model, final_q);
        end
        start = 1'b0;
        stuck_model = 1'b0;
        $display("run cf=%0d n=%0d q0=%0d stuck=%0d done@%0d pulses=%0d wraps=%0d err=%0b q=%0d",
                 cf, n, q0, stuck, done_t, pulses_sent, wrap_count, error, ctr_model);
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b1; clear_first = 1'b1; pulse_count = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp += 2;
            if (cnt_clr_ !== 1'b0) begin
                n_bad++; $display("FAIL reset_clr cyc=%0d got=%0b want=0", i, cnt_clr_);
            end
            if ({cnt_cp, busy, done, pulses_sent, wrap_count, error} !== 19'd0) begin
                n_bad++; $display("FAIL reset_outs cyc=%0d got=%0h want=0", i,
                                  {cnt_cp, busy, done, pulses_sent, wrap_count, error});
            end
        end
        clear = 1'b0; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp += 2;
            if (cnt_clr_ !== 1'b1) begin
                n_bad++; $display("FAIL post_reset_clr cyc=%0d got=%0b want=1", i, cnt_clr_);
            end
            if (busy !== 1'b0 || cnt_cp !== 1'b0) begin
                n_bad++; $display("FAIL post_reset_idle cyc=%0d busy=%0b cp=%0b want 0/0", i, busy, cnt_cp);
            end
        end
        $display("reset: cnt_clr_ low during reset, idle afterwards");
    endtask

    task automatic test_clear_run();      do_run(1'b1, 5, 1'b0, 0, 1'b0, 0);     endtask
    task automatic test_preload_run();    do_run(1'b0, 3, 1'b1, 2, 1'b0, 0);     endtask
    task automatic test_wrap_255();       do_run(1'b0, 255, 1'b1, 3, 1'b0, 0);   endtask

    task automatic test_stuck();
        do_run(1'b1, 4, 1'b0, 0, 1'b1, 0);
        do_run(1'b1, 2, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_zero_count();
        do_run(1'b1, 0, 1'b0, 0, 1'b0, 0);
        do_run(1'b0, 0, 1'b1, 1, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        do_run(1'b1, 6, 1'b0, 0, 1'b0, 9);
        do_run(1'b0, 2, 1'b1, 1, 1'b0, 1 + 2 * H_T * 2);
    endtask

    task automatic test_back_to_back();
        do_run(1'b0, 3, 1'b0, 0, 1'b0, 0);
        do_run(1'b0, 2, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            bit cf = 1'($urandom);
            int n  = $urandom_range(0, 20);
            int q  = $urandom_range(0, 3);
            bit st = ($urandom_range(0, 3) == 0);
            do_run(cf, n, !cf, q, st, 0);
        end
    endtask

    task automatic test_reset_midrun();
        int waited = 0;
        start = 1'b1; clear_first = 1'b0; pulse_count = 8'd10;
        @(negedge clk);
        start = 1'b0;
        while (cnt_cp !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (cnt_cp !== 1'b1) begin
            n_bad++; $display("FAIL midrun_wait_cp got=%0b want=1 after %0d cycles", cnt_cp, waited);
        end
        clear = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (cnt_cp !== 1'b0 || busy !== 1'b0 || cnt_clr_ !== 1'b0) begin
            n_bad++; $display("FAIL midrun_abort cp=%0b busy=%0b clr_=%0b want 0/0/0", cnt_cp, busy, cnt_clr_);
        end
        if ({done, pulses_sent, wrap_count, error} !== 17'd0) begin
            n_bad++; $display("FAIL midrun_counts got=%0h want=0", {done, pulses_sent, wrap_count, error});
        end
        clear = 1'b0;
        for (int i = 0; i < 4 * H_T * 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cnt_cp !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL midrun_quiet cyc=%0d cp=%0b busy=%0b want 0/0", i, cnt_cp, busy);
            end
        end
        $display("reset mid-run: aborted, no further pulses");
    endtask

    initial begin
        test_reset();
        test_clear_run();
        test_preload_run();
        test_stuck();
        test_zero_count();
        test_wrap_255();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
